// File: rtl/macro_adder_tester.sv
// Stimulus/response engine for the doubled-nibble adder macro (out = {e,e}, e = (in<<1)[3:0]).
// Define ADDER_TEST_LFSR_EN to source operands from a 4-bit LFSR instead of a counter.
module macro_adder_tester #(
   parameter int DUT_LATENCY = 1,
   parameter int NUM_VECS    = 16,
   parameter int ERR_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   output logic [3:0]       dut_in_o,
   input  logic [7:0]       dut_out_i,
   input  logic             dut_carry_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             pass_o,
   output logic [ERR_W-1:0] err_count_o,
   output logic [3:0]       fail_vec_o
);
   localparam int               STAGES     = DUT_LATENCY + 1;
   localparam logic [7:0]       LAST_VEC   = 8'(NUM_VECS);
   localparam logic [2:0]       LAST_DRAIN = 3'(DUT_LATENCY);
   localparam logic [ERR_W-1:0] ERR_MAX    = '1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

`ifdef ADDER_TEST_LFSR_EN
   localparam logic [3:0] SEED = 4'h1;
   // x^4+x^3+1, maximal length 15, never reaches 0 from a nonzero seed
   function automatic logic [3:0] gen_next(input logic [3:0] q);
      return {q[2:0], q[3] ^ q[2]};
   endfunction
`else
   localparam logic [3:0] SEED = 4'h0;
   function automatic logic [3:0] gen_next(input logic [3:0] q);
      return q + 4'd1;
   endfunction
`endif

   state_t               state;
   logic [3:0]           gen;
   logic [7:0]           vec_cnt;
   logic [2:0]           drain_cnt;
   // stage j holds the operand driven j cycles ago; stage 0 is the live dut_in_o
   logic [STAGES:0]      vld_pipe;
   logic [STAGES:0][3:0] op_pipe;
   logic                 out_err_q;

   logic                 chk_en;
   logic [3:0]           e_nib;
   logic                 out_bad;
   logic                 vec_fail;
   logic [ERR_W-1:0]     err_nxt;

   assign dut_in_o = op_pipe[0];

   // out is judged one stage before carry; its verdict rides along so each
   // vector is scored exactly once, when its carry is checked
   always_comb begin
      chk_en   = (state == RUN) || (state == DRAIN);
      e_nib    = {op_pipe[DUT_LATENCY][2:0], 1'b0};
      out_bad  = vld_pipe[DUT_LATENCY] && (dut_out_i != {e_nib, e_nib});
      vec_fail = chk_en && vld_pipe[STAGES] &&
                 (out_err_q || (dut_carry_i != op_pipe[STAGES][3]));
      err_nxt  = err_count_o;
      if (vec_fail && (err_count_o != ERR_MAX))
         err_nxt = err_count_o + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         gen         <= SEED;
         vec_cnt     <= '0;
         drain_cnt   <= '0;
         vld_pipe    <= '0;
         op_pipe     <= '0;
         out_err_q   <= 1'b0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         pass_o      <= 1'b0;
         err_count_o <= '0;
         fail_vec_o  <= '0;
      end else begin
         vld_pipe            <= {vld_pipe[STAGES-1:0], 1'b0};
         op_pipe[STAGES:1]   <= op_pipe[STAGES-1:0];
         out_err_q           <= chk_en && out_bad;
         err_count_o         <= err_nxt;
         done_o              <= 1'b0;
         if (vec_fail && (err_count_o == '0))
            fail_vec_o <= op_pipe[STAGES];

         case (state)
            IDLE, DONE: begin
               if (start_i) begin
                  state       <= RUN;
                  busy_o      <= 1'b1;
                  pass_o      <= 1'b0;
                  err_count_o <= '0;
                  fail_vec_o  <= '0;
                  op_pipe[0]  <= SEED;
                  gen         <= gen_next(SEED);
                  vec_cnt     <= 8'd1;
                  vld_pipe    <= {{STAGES{1'b0}}, 1'b1};
                  out_err_q   <= 1'b0;
               end
            end
            RUN: begin
               if (vec_cnt == LAST_VEC) begin
                  state     <= DRAIN;
                  drain_cnt <= '0;
               end else begin
                  op_pipe[0]  <= gen;
                  gen         <= gen_next(gen);
                  vec_cnt     <= vec_cnt + 8'd1;
                  vld_pipe[0] <= 1'b1;
               end
            end
            DRAIN: begin
               if (drain_cnt == LAST_DRAIN) begin
                  state  <= DONE;
                  busy_o <= 1'b0;
                  done_o <= 1'b1;
                  pass_o <= (err_nxt == '0);
               end else begin
                  drain_cnt <= drain_cnt + 3'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_macro_adder_tester.sv
// Bench for macro_adder_tester: behavioural adder macro with injectable faults,
// expected results computed from the operand sequence and fault tables.
module tb_macro_adder_tester;
   localparam int LAT_A = 1, NV_A = 16, EW_A = 8;
   localparam int LAT_B = 3, NV_B = 11, EW_B = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic            start_a = 1'b0, start_b = 1'b0;
   logic [3:0]      in_a, in_b, fail_a, fail_b;
   logic [7:0]      out_a;
   logic            car_a;
   logic            busy_a, done_a, pass_a, busy_b, done_b, pass_b;
   logic [EW_A-1:0] err_a;
   logic [EW_B-1:0] err_b;

   int n_chk  = 0;
   int n_pass = 0;

   macro_adder_tester #(.DUT_LATENCY(LAT_A), .NUM_VECS(NV_A), .ERR_W(EW_A)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .start_i(start_a), .dut_in_o(in_a),
      .dut_out_i(out_a), .dut_carry_i(car_a), .busy_o(busy_a), .done_o(done_a),
      .pass_o(pass_a), .err_count_o(err_a), .fail_vec_o(fail_a));

   // second instance sees a macro with all outputs tied low
   macro_adder_tester #(.DUT_LATENCY(LAT_B), .NUM_VECS(NV_B), .ERR_W(EW_B)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .start_i(start_b), .dut_in_o(in_b),
      .dut_out_i(8'h00), .dut_carry_i(1'b0), .busy_o(busy_b), .done_o(done_b),
      .pass_o(pass_b), .err_count_o(err_b), .fail_vec_o(fail_b));

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   function automatic logic [7:0] ideal(input logic [3:0] v);
      logic [3:0] e;
      e = v << 1;
      return {e, e};
   endfunction

   function automatic logic [3:0] op_at(input int i);
`ifdef ADDER_TEST_LFSR_EN
      logic [3:0] tab [15];
      tab = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
              4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
      return tab[i % 15];
`else
      return 4'(i % 16);
`endif
   endfunction

   // adder macro model for instance A: out lags in by LAT_A cycles, carry by one more;
   // faults are xor masks keyed by operand value
   logic [3:0] hist_a [0:LAT_A];
   logic [7:0] oxor [0:15];
   logic       cxor [0:15];
   always @(posedge clk) begin
      hist_a[0] <= in_a;
      for (int j = 1; j <= LAT_A; j++) hist_a[j] <= hist_a[j-1];
   end
   assign out_a = ideal(hist_a[LAT_A-1]) ^ oxor[hist_a[LAT_A-1]];
   assign car_a = hist_a[LAT_A][3] ^ cxor[hist_a[LAT_A]];

   task automatic clear_faults();
      for (int v = 0; v < 16; v++) begin
         oxor[v] = 8'h00;
         cxor[v] = 1'b0;
      end
   endtask

   task automatic run_a(input string tag, input bit poke);
      int exp_err = 0, exp_fail = 0, cyc = 0, busy_bad = 0;
      bit seen = 0;
      logic [3:0] v;
      for (int i = 0; i < NV_A; i++) begin
         v = op_at(i);
         if (oxor[v] != 8'h00 || cxor[v]) begin
            if (exp_err == 0) exp_fail = int'(v);
            exp_err++;
         end
      end
      if (exp_err > (1 << EW_A) - 1) exp_err = (1 << EW_A) - 1;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk) start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
      while (!seen && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
         start_a = 1'b0;
         // starts during RUN and the last DRAIN cycle must be ignored
         if (poke && (cyc == 5 || cyc == NV_A + LAT_A)) start_a = 1'b1;
         if (done_a) seen = 1;
         else if (!busy_a) busy_bad++;
      end
      chk({tag, " done_latency"}, cyc, NV_A + LAT_A + 1);
      chk({tag, " busy_gaps"}, busy_bad, 0);
      chk({tag, " pass"}, int'(pass_a), int'(exp_err == 0));
      chk({tag, " err_count"}, int'(err_a), exp_err);
      chk({tag, " fail_vec"}, int'(fail_a), exp_fail);
      @(posedge clk); #1;
      chk({tag, " done_pulse_1cyc"}, int'({done_a, busy_a}), 0);
      chk({tag, " err_held"}, int'(err_a), exp_err);
   endtask

   initial begin
      int exp_err, exp_fail, cyc;
      bit seen;
      logic [3:0] v;

      clear_faults();
      for (int j = 0; j <= LAT_A; j++) hist_a[j] = 4'h0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // idle after reset, no start
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         chk("idle_a", int'({in_a, busy_a, done_a, pass_a, err_a, fail_a}), 0);
         chk("idle_b", int'({in_b, busy_b, done_b, pass_b, err_b, fail_b}), 0);
      end

      run_a("ideal", 1'b0);

      clear_faults();
      oxor[3] = 8'h20;
      run_a("out5_v3", 1'b1);

      clear_faults();
      for (int k = 0; k < 16; k++) cxor[k] = k[3];
      run_a("carry_stuck0", 1'b0);

      for (int r = 0; r < 6; r++) begin
         for (int k = 0; k < 16; k++) begin
            oxor[k] = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            cxor[k] = ($urandom_range(0, 5) == 0);
         end
         run_a($sformatf("rand%0d", r), 1'b1);
      end

      // saturation on the narrow-counter instance against an all-zero macro
      exp_err = 0; exp_fail = 0;
      for (int i = 0; i < NV_B; i++) begin
         v = op_at(i);
         if (ideal(v) != 8'h00 || v[3]) begin
            if (exp_err == 0) exp_fail = int'(v);
            exp_err++;
         end
      end
      if (exp_err > (1 << EW_B) - 1) exp_err = (1 << EW_B) - 1;
      @(negedge clk) start_b = 1'b1;
      @(negedge clk) start_b = 1'b0;
      cyc = 0; seen = 0;
      while (!seen && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
         if (done_b) seen = 1;
      end
      chk("sat done_latency", cyc, NV_B + LAT_B + 1);
      chk("sat pass", int'(pass_b), 0);
      chk("sat err_count", int'(err_b), exp_err);
      chk("sat fail_vec", int'(fail_b), exp_fail);

      // reset in the middle of a run
      clear_faults();
      oxor[0] = 8'h01;
      @(negedge clk) start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
      end
      chk("midrst vec5", int'(in_a), int'(op_at(5)));
      chk("midrst busy_before", int'(busy_a), 1);
      rst_n = 1'b0;
      #1;
      chk("midrst outputs", int'({in_a, busy_a, done_a, pass_a, err_a, fail_a}), 0);
      @(negedge clk);
      @(negedge clk) rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #1;
         if (done_a || busy_a) seen = 1;
      end
      chk("midrst no_done", int'(seen), 0);

      clear_faults();
      run_a("post_rst", 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
